// File: rtl/operand_sel_seq.sv
// rtl/operand_sel_seq.sv - registered operand/register-index selector with DIRECT and SCAN modes
// Requests are sampled only on acceptance; beats leave through a valid/ready port.
module operand_sel_seq #(
   parameter int unsigned       WIDTH       = 32,
   parameter int unsigned       NUM_IN      = 4,
   parameter int unsigned       SEL_W       = 2,
   parameter int unsigned       MASK_W      = 16,
   parameter int unsigned       IDX_W       = 4,
   parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   input  logic [MASK_W-1:0]       mask,
   input  logic                    req_valid,
   output logic                    req_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    sel_err,
   output logic                    busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  data_q,  data_d;
   logic              valid_q, valid_d;
   logic              last_q,  last_d;
   logic              err_q,   err_d;
   logic [MASK_W-1:0] rem_q,   rem_d;

   logic [WIDTH-1:0]  word_sel;
   logic              sel_hit;
   logic [IDX_W-1:0]  first_idx;
   logic              first_last;
   logic [MASK_W-1:0] rem_next;
   logic [IDX_W-1:0]  rem_next_idx;
   logic              rem_next_last;
   logic              beat_take;
   logic              last_take;
   logic              accept;

   function automatic logic [IDX_W-1:0] low_idx(input logic [MASK_W-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   function automatic logic one_bit(input logic [MASK_W-1:0] m);
      return (m != '0) && ((m & (m - MASK_W'(1))) == '0);
   endfunction

   // Compare against each legal index so an out-of-range select never slices past in_bus.
   always_comb begin
      word_sel = DEFAULT_VAL;
      sel_hit  = 1'b0;
      for (int k = 0; k < int'(NUM_IN); k++) begin
         if (sel == SEL_W'(k)) begin
            word_sel = in_bus[k*WIDTH +: WIDTH];
            sel_hit  = 1'b1;
         end
      end
   end

   always_comb begin
      first_idx     = low_idx(mask);
      first_last    = one_bit(mask);
      rem_next      = rem_q & (rem_q - MASK_W'(1));
      rem_next_idx  = low_idx(rem_next);
      rem_next_last = one_bit(rem_next);
   end

   assign beat_take = valid_q & out_ready;
   assign last_take = beat_take & last_q;
   assign req_ready = reset_n & ((state_q == ST_IDLE) | last_take);
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = err_q;
      rem_d   = rem_q;
      if (accept) begin
         valid_d = 1'b1;
         if (!mode) begin
            state_d = ST_DIRECT;
            data_d  = sel_hit ? word_sel : DEFAULT_VAL;
            last_d  = 1'b1;
            err_d   = ~sel_hit;
            rem_d   = '0;
         end else if (mask == '0) begin
            // An empty list still yields one error beat, handled like a DIRECT beat.
            state_d = ST_DIRECT;
            data_d  = '0;
            last_d  = 1'b1;
            err_d   = 1'b1;
            rem_d   = '0;
         end else begin
            state_d = ST_SCAN;
            data_d  = WIDTH'(first_idx);
            last_d  = first_last;
            err_d   = 1'b0;
            rem_d   = mask;
         end
      end else if (last_take) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         last_d  = 1'b0;
         err_d   = 1'b0;
         rem_d   = '0;
      end else if (beat_take && (state_q == ST_SCAN)) begin
         rem_d  = rem_next;
         data_d = WIDTH'(rem_next_idx);
         last_d = rem_next_last;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         rem_q   <= rem_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign sel_err   = err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_operand_sel_seq.sv
// tb/tb_operand_sel_seq.sv - self-checking bench for operand_sel_seq
// Expected beats come from a per-request beat list built from the selection rules.
module tb_operand_sel_seq;

   localparam int          W   = 32;
   localparam int          NI  = 3;
   localparam logic [31:0] DEF = 32'hDEAD_BEEF;

   logic          clk;
   logic          reset_n;
   logic [NI*W-1:0] in_bus;
   logic [1:0]    sel;
   logic          mode;
   logic [15:0]   mask;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          sel_err;
   logic          busy;

   operand_sel_seq #(
      .WIDTH(W), .NUM_IN(NI), .SEL_W(2), .MASK_W(16), .IDX_W(4), .DEFAULT_VAL(DEF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_bus(in_bus), .sel(sel), .mode(mode),
      .mask(mask), .req_valid(req_valid), .req_ready(req_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .sel_err(sel_err), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        e;
   } beat_t;

   beat_t expq[$];
   int    checks = 0;
   int    errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic md, input logic [1:0] s, input logic [15:0] m,
                           input logic [NI*W-1:0] bus);
      beat_t b;
      int    n;
      int    k;
      if (!md) begin
         if (int'(s) < NI) b = '{d: bus[int'(s)*W +: W], l: 1'b1, e: 1'b0};
         else              b = '{d: DEF, l: 1'b1, e: 1'b1};
         expq.push_back(b);
      end else if (m == 16'h0) begin
         expq.push_back('{d: 32'h0, l: 1'b1, e: 1'b1});
      end else begin
         n = $countones(m);
         k = 0;
         for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
               k++;
               expq.push_back('{d: 32'(i), l: (k == n), e: 1'b0});
            end
         end
      end
   endtask

   // Called at a falling edge: check outputs, drive the next cycle, update the model.
   task automatic step(input logic rv, input logic rdy, input logic md,
                       input logic [1:0] s, input logic [15:0] m, input logic rnd_bus);
      logic exp_valid;
      logic exp_rdy;
      exp_valid = (expq.size() != 0);
      chk("out_valid", out_valid, exp_valid);
      chk("busy", busy, exp_valid);
      if (exp_valid) begin
         chk("out_data", out_data, expq[0].d);
         chk("out_last", out_last, expq[0].l);
         chk("sel_err", sel_err, expq[0].e);
      end
      req_valid = rv;
      out_ready = rdy;
      mode      = md;
      sel       = s;
      mask      = m;
      if (rnd_bus) in_bus = {$urandom, $urandom, $urandom};
      #1;
      exp_rdy = (expq.size() == 0) || (rdy && expq.size() == 1);
      chk("req_ready", req_ready, exp_rdy);
      if (exp_valid && rdy) void'(expq.pop_front());
      if (rv && exp_rdy) push_req(md, s, m, in_bus);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] rm;
      reset_n   = 1'b0;
      in_bus    = {32'hC2, 32'hB1, 32'hA0};
      sel       = 2'd0;
      mode      = 1'b0;
      mask      = 16'h0;
      req_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_sel_err", sel_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      req_valid = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);

      // DIRECT sel=1: one beat, one cycle after acceptance
      step(1, 0, 0, 2'd1, 16'h0, 0);
      chk("t1_data", out_data, 32'hB1);
      chk("t1_last", out_last, 1'b1);
      step(0, 1, 0, 2'd0, 16'h0, 0);
      step(0, 1, 0, 2'd0, 16'h0, 0);

      // Out-of-range select, then stall while in_bus changes
      step(1, 0, 0, 2'd3, 16'h0, 0);
      chk("t2_default", out_data, DEF);
      chk("t2_err", sel_err, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 16'h0, 1);
      step(0, 1, 0, 2'd0, 16'h0, 1);
      step(1, 0, 0, 2'd2, 16'h0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 16'h0, 1);
      step(0, 1, 0, 2'd0, 16'h0, 0);

      // SCAN 0x8025 with continuous consumption
      step(1, 1, 1, 2'd0, 16'h8025, 0);
      chk("t3_first", out_data, 32'd0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 2'd0, 16'h0, 0);

      // SCAN 0x0006 with alternating ready, then an empty mask
      step(1, 0, 1, 2'd0, 16'h0006, 0);
      for (int i = 0; i < 5; i++) step(0, logic'(i % 2), 1, 2'd0, 16'h0, 1);
      step(1, 0, 1, 2'd0, 16'h0000, 0);
      chk("t4_empty_err", sel_err, 1'b1);
      step(0, 1, 0, 2'd0, 16'h0, 0);
      step(0, 1, 0, 2'd0, 16'h0, 0);

      // Back-to-back: DIRECT followed immediately by SCAN 0x0001
      step(1, 1, 0, 2'd0, 16'h0, 0);
      step(1, 1, 1, 2'd0, 16'h0001, 0);
      chk("t5_no_bubble", out_valid, 1'b1);
      step(0, 1, 0, 2'd0, 16'h0, 0);
      step(0, 1, 0, 2'd0, 16'h0, 0);

      // Reset in the middle of a full-mask scan
      step(1, 1, 1, 2'd0, 16'hFFFF, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 2'd0, 16'h0, 0);
      req_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_req_ready", req_ready, 1'b0);
      chk("t6_data", out_data, 32'h0);
      chk("t6_last", out_last, 1'b0);
      expq.delete();
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1, 0, 2'd0, 16'h0, 0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 3))
            0:       rm = 16'h0;
            1:       rm = 16'($urandom) & 16'($urandom);
            2:       rm = 16'h1 << $urandom_range(0, 15);
            default: rm = 16'($urandom);
         endcase
         step(logic'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rm, 1);
      end
      for (int i = 0; i < 40; i++) step(0, 1, 0, 2'd0, 16'h0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
